// File: rtl/fde_machine_pkg.sv
// rtl/fde_machine_pkg.sv - shared phase encodings and widths for the fetch/decode/execute sequencer
//
// Purpose : single source of truth for the phase codes used by the control
//           unit and anything that decodes its state output.
// Contents: fde_state_e (FETCH/DECODE/EXECUTE/HALT), COUNT_W.
package fde_machine_pkg;

    // All four codes are used, so the state register has no illegal value.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_DECODE  = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_HALT    = 2'b11
    } fde_state_e;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/fde_counter.sv
// rtl/fde_counter.sv - completed-instruction counter with enable and natural wrap
//
// Purpose : counts EXECUTE completions; wraps from all-ones to zero.
// Ports   : clk    - rising-edge clock
//           reset  - asynchronous active-low reset, clears the count
//           en     - advance enable; count holds when low
//           inc    - add one on the next enabled edge
//           count  - current count
module fde_counter
    import fde_machine_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Plain modular add gives the FFFF -> 0000 wrap for free.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fde_machine.sv
// rtl/fde_machine.sv - fetch/decode/execute phase sequencer with stall, halt and resume
//
// Purpose : steps FETCH -> DECODE -> EXECUTE, holds EXECUTE while stalled,
//           parks in HALT when halt is seen at an instruction boundary.
// Ports   : clk, reset (async active-low), en (global advance enable),
//           stall, halt, resume (control requests),
//           state (phase code), fetch_phase/decode_phase/exec_phase/halted
//           (one-hot phase decodes), instr_done (completion pulse),
//           instr_count (completed instructions, wrapping).
module fde_machine
    import fde_machine_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               stall,
    input  logic               halt,
    input  logic               resume,
    output logic [1:0]         state,
    output logic               fetch_phase,
    output logic               decode_phase,
    output logic               exec_phase,
    output logic               instr_done,
    output logic [COUNT_W-1:0] instr_count,
    output logic               halted
);

    fde_state_e state_q;
    fde_state_e state_d;
    logic       done_q;
    logic       done_d;
    logic       complete;

    // An instruction completes on an EXECUTE cycle that is not stalled;
    // stall therefore has priority over halt.
    assign complete = (state_q == ST_EXECUTE) && !stall;

    always_comb begin
        state_d = state_q;
        done_d  = complete;
        case (state_q)
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (complete) begin
                    state_d = halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    fde_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .inc   (complete),
        .count (instr_count)
    );

    assign state        = state_q;
    assign fetch_phase  = (state_q == ST_FETCH);
    assign decode_phase = (state_q == ST_DECODE);
    assign exec_phase   = (state_q == ST_EXECUTE);
    assign halted       = (state_q == ST_HALT);
    // done_q holds while en is low, so the pulse is masked rather than lost.
    assign instr_done   = done_q & en;

endmodule

// File: tb/tb_fde_machine.sv
// tb/tb_fde_machine.sv - scoreboard bench for fde_machine against a phase-rule reference model
module tb_fde_machine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [1:0]  state;
    logic        fetch_phase;
    logic        decode_phase;
    logic        exec_phase;
    logic        instr_done;
    logic [15:0] instr_count;
    logic        halted;

    fde_machine dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .stall        (stall),
        .halt         (halt),
        .resume       (resume),
        .state        (state),
        .fetch_phase  (fetch_phase),
        .decode_phase (decode_phase),
        .exec_phase   (exec_phase),
        .instr_done   (instr_done),
        .instr_count  (instr_count),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0=fetch 1=decode 2=execute 3=halt.
    int   m_phase = 0;
    bit   m_done = 1'b0;
    int   m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Applies the phase rules for one enabled, non-reset rising edge.
    task automatic model_edge();
        if (!reset || !en) return;
        m_done = 1'b0;
        case (m_phase)
            0: m_phase = 1;
            1: m_phase = 2;
            2: begin
                if (!stall) begin
                    m_done  = 1'b1;
                    m_cnt   = (m_cnt + 1) % 65536;
                    m_phase = halt ? 3 : 0;
                end
            end
            default: begin
                if (resume) m_phase = 0;
            end
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.st   = 2'(m_phase);
        e.done = m_done & en;
        e.cnt  = 16'(m_cnt);
        exp_q.push_back(e);
    endtask

    // Drive this cycle's inputs, record what the outputs must be now, then take the edge.
    task automatic step(input bit e, input bit s, input bit h, input bit r);
        en = e; stall = s; halt = h; resume = r;
        push_exp();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset pulse placed between clock edges, checked before any edge can occur.
    task automatic do_reset();
        #1;
        reset = 1'b0;
        m_phase = 0; m_done = 1'b0; m_cnt = 0;
        #1;
        check("rst_async_state", 32'(state), 32'd0);
        check("rst_async_count", 32'(instr_count), 32'd0);
        check("rst_async_done", 32'(instr_done), 32'd0);
        push_exp();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_state", 32'(state), 32'(e.st));
                check("sb_done", 32'(instr_done), 32'(e.done));
                check("sb_count", 32'(instr_count), 32'(e.cnt));
                check("sb_onehot", 32'({halted, exec_phase, decode_phase, fetch_phase}), 32'(4'b0001 << e.st));
            end
        end
    end

    initial begin
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_done", 32'(instr_done), 32'd0);
        check("reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Nominal run: 8 enabled edges from FETCH -> two completions, ending in EXECUTE.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
        check("nominal_state", 32'(state), 32'd2);
        check("nominal_count", 32'(instr_count), 32'd2);

        // Stall in EXECUTE for 4 edges, then complete.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        check("stall_hold_state", 32'(state), 32'd2);
        check("stall_hold_count", 32'(instr_count), 32'd2);
        step(1, 0, 0, 0);
        check("stall_exit_state", 32'(state), 32'd0);
        check("stall_exit_done", 32'(instr_done), 32'd1);
        check("stall_exit_count", 32'(instr_count), 32'd3);

        // Halt raised in DECODE, taken only when EXECUTE completes.
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("halt_in_decode_ignored", 32'(state), 32'd2);
        step(1, 0, 1, 0);
        check("halt_state", 32'(state), 32'd3);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_count", 32'(instr_count), 32'd4);
        step(1, 0, 0, 0);
        check("halt_hold", 32'(state), 32'd3);
        step(1, 0, 0, 1);
        check("resume_state", 32'(state), 32'd0);

        // en low in DECODE freezes everything.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1);
        check("en_low_state", 32'(state), 32'd1);
        check("en_low_done", 32'(instr_done), 32'd0);
        check("en_low_count", 32'(instr_count), 32'd4);
        step(1, 0, 0, 0);
        check("en_resume_state", 32'(state), 32'd2);

        // Reset in EXECUTE abandons the instruction.
        step(1, 1, 0, 0);
        do_reset();
        step(1, 0, 0, 0);
        check("post_reset_first_edge", 32'(state), 32'd1);
        check("post_reset_count", 32'(instr_count), 32'd0);

        // Wrap: counter preloaded to FFFE, then two completions.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        dut.u_counter.count_q = 16'hFFFE;
        m_cnt = 65534;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check("wrap_ffff", 32'(instr_count), 32'hFFFF);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check("wrap_zero", 32'(instr_count), 32'h0000);

        // Randomized traffic, occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3);
            end
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
